// File: rtl/rr_arb4_enc_if.sv
// rr_arb4_enc_if
// Bundles the request/release inputs and the registered grant outputs of the
// four-requester round-robin arbiter.
//
// Signals:
//   Req   [3:0]  request vector, bit k belongs to requester k
//   Done         current grantee gives the grant back (meaningful while En=1)
//   W     [1:0]  encoded index of the granted requester (decoder W input)
//   En           grant valid (decoder En input)
//   Tout         one-cycle pulse when a grant is revoked by the hold timeout
//
// Modports:
//   master  requester side: drives Req/Done, observes W/En/Tout
//   slave   arbiter side: observes Req/Done, drives W/En/Tout
interface rr_arb4_enc_if;
    logic [3:0] Req;
    logic       Done;
    logic [1:0] W;
    logic       En;
    logic       Tout;

    modport master (
        output Req,
        output Done,
        input  W,
        input  En,
        input  Tout
    );

    modport slave (
        input  Req,
        input  Done,
        output W,
        output En,
        output Tout
    );
endinterface

// File: rtl/rr_arb4_enc.sv
// rr_arb4_enc
// Four-requester round-robin arbiter that produces the encoded index/enable
// pair for a downstream 2-to-4 decoder. All outputs come straight from
// flops, so the decoder sees stable W/En for whole clock cycles.
//
// Ports:
//   Clock   rising-edge clock
//   Resetn  asynchronous active-low reset
//   bus     rr_arb4_enc_if.slave: Req/Done in, W/En/Tout out
//
// Parameters:
//   TIMEOUT  maximum consecutive En-high cycles for one grant (1..255);
//            only meaningful when the timeout feature is compiled in.
//
// Configuration macro:
//   ARB_TIMEOUT_EN  when defined, a hold counter force-releases a grant after
//                   TIMEOUT cycles and pulses Tout; when undefined there is no
//                   counter and Tout is tied low.
module rr_arb4_enc #(
    parameter int TIMEOUT = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    rr_arb4_enc_if.slave  bus
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("rr_arb4_enc: TIMEOUT must be in 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] ptr;
    logic [1:0] ptr_next;
    logic [1:0] w_q;
    logic [1:0] w_next;
    logic       en_q;
    logic       en_next;
    logic [1:0] pick;
    logic       timeout_hit;

    // Rotating priority search. Walking the offsets from 3 down to 0 lets the
    // lowest offset from ptr overwrite the others, so the first requester at
    // or after ptr (mod 4) wins.
    always_comb begin
        pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (bus.Req[ptr + 2'(i)]) begin
                pick = ptr + 2'(i);
            end
        end
    end

    // Next-state logic. A grant ends on Done, on the grantee dropping its
    // request, or on the hold timeout; the pointer then moves one past the
    // grantee so that it becomes lowest priority in the next arbitration.
    // Leaving GRANT always passes through IDLE, which guarantees one En=0
    // bubble between consecutive grants.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        w_next     = w_q;
        en_next    = en_q;
        case (state)
            IDLE: begin
                if (|bus.Req) begin
                    w_next     = pick;
                    en_next    = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (bus.Done || !bus.Req[w_q] || timeout_hit) begin
                    en_next    = 1'b0;
                    ptr_next   = w_q + 2'd1;
                    state_next = IDLE;
                end
            end
            default: begin
                en_next    = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // State, pointer and registered decoder outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            ptr   <= 2'd0;
            w_q   <= 2'd0;
            en_q  <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            w_q   <= w_next;
            en_q  <= en_next;
        end
    end

    assign bus.W  = w_q;
    assign bus.En = en_q;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       tout_q;
    logic       tout_next;

    // cnt counts completed En-high cycles minus one, so reaching TIMEOUT-1
    // at an edge means En has been high for exactly TIMEOUT cycles.
    assign timeout_hit = (state == GRANT) && (cnt == TIMEOUT_LAST);

    // The counter only runs while a grant is held; any other case (idle,
    // fresh grant, release) leaves it at zero for the next grant. Tout is
    // flagged only when the timeout is the sole reason for the release.
    always_comb begin
        cnt_next  = 8'd0;
        tout_next = 1'b0;
        if (state == GRANT && state_next == GRANT) begin
            cnt_next = cnt + 8'd1;
        end
        if (timeout_hit && !bus.Done && bus.Req[w_q]) begin
            tout_next = 1'b1;
        end
    end

    // Hold counter and registered timeout pulse.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt    <= 8'd0;
            tout_q <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            tout_q <= tout_next;
        end
    end

    assign bus.Tout = tout_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.Tout    = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb4_enc.sv
// tb_rr_arb4_enc
// Exercises rr_arb4_enc with directed sequences (reset mid-grant, rotation,
// pointer wrap, request drop, timeout and Done/timeout collision) followed by
// random traffic, comparing W/En/Tout each cycle against a behavioural model.
// Built with TIMEOUT=4; expectations follow ARB_TIMEOUT_EN if it is defined.
module tb_rr_arb4_enc;

    localparam int TB_TIMEOUT = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] w;
        logic       en;
        logic       tout;
    } exp_t;

    logic Clock;
    logic Resetn;

    rr_arb4_enc_if arb_bus ();

    rr_arb4_enc #(
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (arb_bus)
    );

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state: who holds the grant (-1 for nobody), how many
    // cycles En has been high for that grant, where the next search starts,
    // and the last index shown on W.
    int         owner    = -1;
    int         held     = 0;
    int         next_pri = 0;
    logic [1:0] last_w   = 2'd0;
    logic       m_en     = 1'b0;
    logic       m_tout   = 1'b0;

    // 100 MHz-style free-running clock.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [3:0] actual,
                               input logic [3:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, actual, expected);
        end
    endtask

    task automatic modelReset();
        owner    = -1;
        held     = 0;
        next_pri = 0;
        last_w   = 2'd0;
        m_en     = 1'b0;
        m_tout   = 1'b0;
    endtask

    // One clock edge of arbiter behaviour, expressed as grant ownership.
    task automatic modelStep(input logic [3:0] req, input logic done);
        bit timed_out;
        m_tout = 1'b0;
        if (owner < 0) begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (next_pri + i) % 4;
                if (owner < 0 && req[k]) begin
                    owner  = k;
                    held   = 1;
                    last_w = 2'(k);
                end
            end
        end else begin
            timed_out = TIMEOUT_ON && (held >= TB_TIMEOUT);
            if (done || !req[owner] || timed_out) begin
                m_tout   = timed_out && !done && req[owner];
                next_pri = (owner + 1) % 4;
                owner    = -1;
            end else begin
                held++;
            end
        end
        m_en = (owner >= 0);
    endtask

    // Drive inputs, let the DUT take one edge, and queue the response the
    // model says should follow that edge.
    task automatic applyStimulus(input logic [3:0] req, input logic done);
        exp_t e;
        arb_bus.Req  = req;
        arb_bus.Done = done;
        @(posedge Clock);
        modelStep(req, done);
        e.w    = last_w;
        e.en   = m_en;
        e.tout = m_tout;
        sb.push_back(e);
        #1;
    endtask

    // Outputs are compared mid-cycle, well away from the active edge.
    always @(negedge Clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("W",    4'(arb_bus.W),    4'(e.w));
            checkOutput("En",   4'(arb_bus.En),   4'(e.en));
            checkOutput("Tout", 4'(arb_bus.Tout), 4'(e.tout));
        end
    end

    initial begin
        Resetn       = 1'b0;
        arb_bus.Req  = 4'b0000;
        arb_bus.Done = 1'b0;
        modelReset();
        #2;
        checkOutput("reset_W",    4'(arb_bus.W),    4'd0);
        checkOutput("reset_En",   4'(arb_bus.En),   4'd0);
        checkOutput("reset_Tout", 4'(arb_bus.Tout), 4'd0);
        #15;
        Resetn = 1'b1;

        // Grant requester 2, then hit reset in the middle of the cycle.
        applyStimulus(4'b0100, 1'b0);
        @(negedge Clock);
        #1;
        Resetn = 1'b0;
        #1;
        checkOutput("midreset_W",    4'(arb_bus.W),    4'd0);
        checkOutput("midreset_En",   4'(arb_bus.En),   4'd0);
        checkOutput("midreset_Tout", 4'(arb_bus.Tout), 4'd0);
        modelReset();
        #2;
        Resetn = 1'b1;

        // Full rotation with all requesters active; Done one cycle after each grant.
        for (int g = 0; g < 5; g++) begin
            applyStimulus(4'b1111, 1'b0);
            applyStimulus(4'b1111, 1'b1);
        end

        // Pointer skip and wrap: grant 2, then 0101 gives 0, then 2.
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b1);
        applyStimulus(4'b0101, 1'b0);
        applyStimulus(4'b0101, 1'b1);
        applyStimulus(4'b0101, 1'b0);
        applyStimulus(4'b0000, 1'b0);

        // Request drop on requester 1, then arbitration resumes from 2.
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b1010, 1'b0);
        applyStimulus(4'b0000, 1'b0);

        // Done in IDLE is ignored.
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0);

        // Single requester held: timeouts and re-grants, or a long hold.
        for (int c = 0; c < 24; c++) begin
            applyStimulus(4'b0001, 1'b0);
        end
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0);

        // Done arriving in the 4th En cycle of a grant.
        applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        applyStimulus(4'b0000, 1'b0);

        // Random traffic; requests tend to persist so holds get long.
        begin
            logic [3:0] r;
            r = 4'b0000;
            for (int n = 0; n < 400; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    r = 4'($urandom_range(0, 15));
                end
                applyStimulus(r, ($urandom_range(0, 5) == 0));
            end
        end

        @(negedge Clock);
        #1;
        if (sb.size() != 0) begin
            checkOutput("sb_drained", 4'(sb.size()), 4'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rr_arb4_enc.md
# rr_arb4_enc

Four-requester round-robin arbiter that produces the encoded index and enable pair consumed directly by the 2-to-4 decoder stage. It owns the grant: the decoder turns `W`/`En` into a one-hot select, and this block decides whose index that is and for how long. All outputs are registered, so the decoder sees glitch-free inputs for a full clock cycle.

## Interface

Parameters:
- `TIMEOUT`, 8, maximum consecutive cycles `En` stays high for one grant; legal range 1..255. Used only when `ARB_TIMEOUT_EN` is defined.

Ports:
- `Clock`  in  1  rising-edge clock.
- `Resetn`  in  1  reset, asynchronous, active-low.
- `Req`  in  4  request vector; bit k is requester k.
- `Done`  in  1  current grantee releases the grant; sampled only while `En`=1.
- `W`  out  2  encoded index of the granted requester; feeds decoder `W`.
- `En`  out  1  grant valid; feeds decoder `En`.
- `Tout`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation

- State machine with two states, `IDLE` and `GRANT`, plus a 2-bit rotating pointer `Ptr` and an 8-bit hold counter `Cnt`.
- **IDLE**:
  - If `Req`!=0, select the first set bit searching `Ptr`, `Ptr+1`, `Ptr+2`, `Ptr+3` (mod 4).
  - Load `W` with that index, set `En`=1, clear `Cnt`, and go to `GRANT`.
  - If `Req`==0, stay in `IDLE`; `W` holds its last value.
- **GRANT**: the grant is released when any of the following holds in a cycle:
  - (a) `Done`=1,
  - (b) `Req[W]`=0,
  - (c) the timeout condition is met.
- **On release**: `En`=0, `Ptr`=`W`+1 (mod 4, so 3 wraps to 0), go to `IDLE`. `W` holds its value.
- **Without release**: `Cnt` increments.
- **Priority among release causes**: (a) and (b) are ordinary releases. `Tout`=1 only when (c) is the sole cause. If `Done` and the timeout coincide, `Tout`=0.
- `Done` asserted while in `IDLE` is ignored.
- `Req` changes during `GRANT` on non-granted bits have no effect until the next `IDLE` arbitration.
- **Fairness**: after a grant to k, requester k has the lowest priority in the next arbitration.

## Timing

- **Reset** (`Resetn`=0, immediate, asynchronous, including mid-grant):
  - state `IDLE`, `Ptr`=0, `Cnt`=0, `W`=2'b00, `En`=0, `Tout`=0.
- **Request to grant**: `Req` sampled high at edge N gives `En`=1 and a valid `W` after edge N; the decoder output is valid in cycle N+1.
- **Release latency**: with `Done`=1 sampled at edge M, `En`=0 after edge M.
- **Re-grant bubble**: the earliest next grant appears after edge M+1. There is always exactly one `En`=0 cycle between grants, so the decoder never sees back-to-back different indices with `En` high.
- **Timeout**: `En` is high for exactly `TIMEOUT` cycles, then low. `Tout` is high in the same cycle `En` first goes low, for one cycle.
- `Tout` is registered and deasserts on the following edge.
- **Single requester held high continuously**: it is re-granted after each one-cycle bubble.

## Configuration

- Macro: `ARB_TIMEOUT_EN`.
- **Defined**: `Cnt` and condition (c) are present; a grant is force-released once `Cnt`==`TIMEOUT`-1 without another release cause; `Tout` is driven as above.
- **Undefined**:
  - No counter logic; grants end only on `Done` or a dropped `Req[W]`.
  - `Tout` is tied to 0.
  - `TIMEOUT` is ignored.

## Test plan

- **Reset mid-grant**: grant requester 2 (`W`=2, `En`=1), pulse `Resetn` low mid-cycle -> `En`=0 and `W`=0 immediately; next grant with `Req`=4'b1111 gives `W`=0.
- **Round-robin rotation**: `Req`=4'b1111 held, `Done` pulsed one cycle after each grant -> `W` sequence 0,1,2,3,0 with one `En`=0 cycle between grants.
- **Pointer skip and wrap**: `Ptr`=3 after a grant to 2, `Req`=4'b0101 -> `W`=0; after release, `Req`=4'b0101 -> `W`=2.
- **Request drop**: requester 1 granted, `Req[1]` cleared with `Done`=0 -> `En`=0 next cycle, `Tout`=0, next arbitration starts from `Ptr`=2.
- **Timeout** (`ARB_TIMEOUT_EN` defined, `TIMEOUT`=4): `Req`=4'b0001 held, `Done`=0 -> `En` high exactly 4 cycles, `Tout`=1 for 1 cycle, re-grant `W`=0 after the bubble.
- **Done/timeout collision** (`ARB_TIMEOUT_EN` defined, `TIMEOUT`=4): `Done`=1 in the 4th `En` cycle -> `En`=0, `Tout`=0.
- **Timeout compiled out** (macro undefined): same stimulus as the timeout case -> `En` stays high 20+ cycles, `Tout` never asserts.
